// File: rtl/mdio_pkg.sv
// Shared Clause 22 MDIO definitions: frame field widths, opcodes and the
// responder state enum. The station block imports the same package.
package mdio_pkg;

  localparam int PHYAD_BITS = 5;
  localparam int REGAD_BITS = 5;
  localparam int TA_BITS    = 2;
  localparam int DATA_BITS  = 16;
  localparam int CNT_BITS   = 6;
  localparam int SKIP_BITS  = TA_BITS + DATA_BITS;

  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  typedef enum logic [3:0] {
    HUNT,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    WR_DATA,
    RD_DATA,
    SKIP
  } mdio_state_e;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// Brings MDC and MDIO into the clk domain through 2-flop synchronizers and
// turns MDC rising edges into single-cycle pulses.
module mdio_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic mdc,
  input  logic mdio_in,
  output logic mdc_rise,
  output logic mdio_s
);

  localparam int N_CH = 2;

  logic [N_CH-1:0] async_in;
  logic [N_CH-1:0] sync_out;
  logic            mdc_prev_q;
  logic            mdc_prev_d;

  assign async_in = {mdio_in, mdc};

  // Bit 0 carries MDC, bit 1 carries MDIO; both see the same two-stage delay
  // so a data sample taken on the rise pulse lines up with that MDC edge.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_sync
      logic [1:0] stage_q;
      logic [1:0] stage_d;

      always_comb begin
        stage_d = {stage_q[0], async_in[gi]};
      end

      always_ff @(posedge clk) begin
        if (!resetn) begin
          stage_q <= 2'b00;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign sync_out[gi] = stage_q[1];
    end
  endgenerate

  always_comb begin
    mdc_prev_d = sync_out[0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mdc_prev_q <= 1'b0;
    end else begin
      mdc_prev_q <= mdc_prev_d;
    end
  end

  assign mdc_rise = sync_out[0] & ~mdc_prev_q;
  assign mdio_s   = sync_out[1];

endmodule

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder: parses frames on MDC rising edges,
// serves register reads by driving MDIO and emits one-clk write strobes.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_BITS-1:0] PHY_ADDRESS  = 5'b00001,
  parameter int                    MIN_PREAMBLE = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mdc,
  input  logic                  mdio_in,
  output logic                  mdio_out,
  output logic                  mdio_oe,
  output logic [REGAD_BITS-1:0] reg_rd_adr,
  input  logic [DATA_BITS-1:0]  reg_rd_data,
  output logic                  reg_wr_valid,
  output logic [REGAD_BITS-1:0] reg_wr_adr,
  output logic [DATA_BITS-1:0]  reg_wr_data,
  output logic                  frame_err
);

  localparam logic [CNT_BITS-1:0] PRE_MAX   = CNT_BITS'(MIN_PREAMBLE);
  localparam logic [CNT_BITS-1:0] PHY_LAST  = CNT_BITS'(PHYAD_BITS - 1);
  localparam logic [CNT_BITS-1:0] REG_LAST  = CNT_BITS'(REGAD_BITS - 1);
  localparam logic [CNT_BITS-1:0] DATA_LAST = CNT_BITS'(DATA_BITS - 1);
  localparam logic [CNT_BITS-1:0] DATA_END  = CNT_BITS'(DATA_BITS);
  localparam logic [CNT_BITS-1:0] SKIP_LAST = CNT_BITS'(SKIP_BITS - 1);

  logic mdc_rise;
  logic sample;

  mdio_sync_edge u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .mdc      (mdc),
    .mdio_in  (mdio_in),
    .mdc_rise (mdc_rise),
    .mdio_s   (sample)
  );

  mdio_state_e           state_q,      state_d;
  logic [CNT_BITS-1:0]   cnt_q,        cnt_d;
  logic [1:0]            op_q,         op_d;
  logic                  phy_ok_q,     phy_ok_d;
  logic [DATA_BITS-1:0]  shift_q,      shift_d;
  logic [REGAD_BITS-1:0] regad_q,      regad_d;
  logic [REGAD_BITS-1:0] rd_adr_q,     rd_adr_d;
  logic                  oe_q,         oe_d;
  logic                  out_q,        out_d;
  logic                  wr_valid_q,   wr_valid_d;
  logic [REGAD_BITS-1:0] wr_adr_q,     wr_adr_d;
  logic [DATA_BITS-1:0]  wr_data_q,    wr_data_d;
  logic                  err_q,        err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      op_q       <= '0;
      phy_ok_q   <= 1'b0;
      shift_q    <= '0;
      regad_q    <= '0;
      rd_adr_q   <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_adr_q   <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      phy_ok_q   <= phy_ok_d;
      shift_q    <= shift_d;
      regad_q    <= regad_d;
      rd_adr_q   <= rd_adr_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      wr_valid_q <= wr_valid_d;
      wr_adr_q   <= wr_adr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    phy_ok_d   = phy_ok_q;
    shift_d    = shift_q;
    regad_d    = regad_q;
    rd_adr_d   = rd_adr_q;
    oe_d       = oe_q;
    out_d      = out_q;
    wr_valid_d = 1'b0;
    wr_adr_d   = wr_adr_q;
    wr_data_d  = wr_data_q;
    err_d      = 1'b0;

    if (mdc_rise) begin
      unique case (state_q)
        HUNT: begin
          if (sample != ST[1]) begin
            if (cnt_q != PRE_MAX) cnt_d = cnt_q + 1'b1;
          end else if (cnt_q == PRE_MAX) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = '0;
          end
        end

        START: begin
          cnt_d = '0;
          if (sample == ST[0]) begin
            state_d = OP;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end

        OP: begin
          op_d = {op_q[0], sample};
          if (cnt_q == '0) begin
            cnt_d = 1;
          end else begin
            cnt_d = '0;
            if (op_is_valid({op_q[0], sample})) begin
              state_d = PHYAD;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
        end

        PHYAD: begin
          shift_d = {shift_q[DATA_BITS-2:0], sample};
          if (cnt_q == PHY_LAST) begin
            cnt_d    = '0;
            phy_ok_d = ({shift_q[PHYAD_BITS-2:0], sample} == PHY_ADDRESS);
            state_d  = REGAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // REGAD is always clocked in so SKIP only has to swallow TA + data.
        REGAD: begin
          regad_d = {regad_q[REGAD_BITS-2:0], sample};
          if (cnt_q == REG_LAST) begin
            cnt_d = '0;
            if (!phy_ok_q) begin
              state_d = SKIP;
            end else begin
              state_d = TA;
              if (op_q == OP_READ) rd_adr_d = {regad_q[REGAD_BITS-2:0], sample};
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        TA: begin
          if (op_q == OP_READ) begin
            shift_d = reg_rd_data;
            oe_d    = 1'b1;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = RD_DATA;
          end else if (cnt_q == '0) begin
            if (sample == TA_WRITE[1]) begin
              cnt_d = 1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else begin
            cnt_d = '0;
            if (sample == TA_WRITE[0]) begin
              state_d = WR_DATA;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
        end

        WR_DATA: begin
          shift_d = {shift_q[DATA_BITS-2:0], sample};
          if (cnt_q == DATA_LAST) begin
            wr_valid_d = 1'b1;
            wr_adr_d   = regad_q;
            wr_data_d  = {shift_q[DATA_BITS-2:0], sample};
            cnt_d      = '0;
            state_d    = HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        // Our own drive is on the pad here, so the sampled bit is never used.
        RD_DATA: begin
          if (cnt_q == DATA_END) begin
            oe_d    = 1'b0;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = HUNT;
          end else begin
            out_d   = shift_q[DATA_BITS-1];
            shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end

        SKIP: begin
          if (cnt_q == SKIP_LAST) begin
            cnt_d   = '0;
            state_d = HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = HUNT;
          cnt_d   = '0;
          oe_d    = 1'b0;
          out_d   = 1'b0;
        end
      endcase
    end
  end

  assign mdio_out     = out_q;
  assign mdio_oe      = oe_q;
  assign reg_rd_adr   = rd_adr_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_adr   = wr_adr_q;
  assign reg_wr_data  = wr_data_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Station-side bench for mdio_responder: a table of directed frames, a reset
// abort sequence and random frames checked against a frame-level model.
module tb_mdio_responder;

  localparam logic [4:0] MY_PHY  = 5'b00001;
  localparam int         MIN_PRE = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mdc = 1'b0;
  logic        mdio_st = 1'b1;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_pad;
  logic [4:0]  reg_rd_adr;
  logic [15:0] reg_rd_data;
  logic        reg_wr_valid;
  logic [4:0]  reg_wr_adr;
  logic [15:0] reg_wr_data;
  logic        frame_err;

  logic [15:0] regfile [32];

  // Pad: the DUT wins while enabled, otherwise the station (or pull-up).
  assign mdio_pad    = mdio_oe ? mdio_out : mdio_st;
  assign reg_rd_data = regfile[reg_rd_adr];

  always #4 clk = ~clk;

  mdio_responder #(.PHY_ADDRESS(MY_PHY), .MIN_PREAMBLE(MIN_PRE)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mdc          (mdc),
    .mdio_in      (mdio_pad),
    .mdio_out     (mdio_out),
    .mdio_oe      (mdio_oe),
    .reg_rd_adr   (reg_rd_adr),
    .reg_rd_data  (reg_rd_data),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_adr   (reg_wr_adr),
    .reg_wr_data  (reg_wr_data),
    .frame_err    (frame_err)
  );

  int          wr_cycles = 0;
  int          err_cycles = 0;
  int          oe_cycles = 0;
  logic [4:0]  seen_wr_adr = '0;
  logic [15:0] seen_wr_data = '0;

  always @(posedge clk) begin
    if (reg_wr_valid) begin
      wr_cycles    <= wr_cycles + 1;
      seen_wr_adr  <= reg_wr_adr;
      seen_wr_data <= reg_wr_data;
    end
    if (frame_err) err_cycles <= err_cycles + 1;
    if (mdio_oe)   oe_cycles  <= oe_cycles + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rega;
    logic [1:0]  ta;
    logic [15:0] wdata;
  } frame_t;

  typedef struct {
    frame_t f;
    bit     exp_rd;
    bit     exp_wr;
    bit     exp_err;
  } vec_t;

  function automatic vec_t mk(input int pre, input logic [1:0] st, input logic [1:0] op,
                              input logic [4:0] phy, input logic [4:0] rega, input logic [1:0] ta,
                              input logic [15:0] wdata, input bit rd, input bit wr, input bit err);
    vec_t v;
    v.f.pre = pre; v.f.st = st; v.f.op = op; v.f.phy = phy;
    v.f.rega = rega; v.f.ta = ta; v.f.wdata = wdata;
    v.exp_rd = rd; v.exp_wr = wr; v.exp_err = err;
    return v;
  endfunction

  // Frame-level outcome from the Clause 22 rules, independent of the bit timing.
  function automatic void predict(input frame_t f, output bit rd, output bit wr, output bit err);
    rd = 0; wr = 0; err = 0;
    if (f.pre < MIN_PRE) return;
    if (f.st != 2'b01) begin err = 1; return; end
    if (f.op != 2'b10 && f.op != 2'b01) begin err = 1; return; end
    if (f.phy != MY_PHY) return;
    if (f.op == 2'b10) rd = 1;
    else if (f.ta == 2'b10) wr = 1;
    else err = 1;
  endfunction

  task automatic run_frame(input frame_t f, input bit exp_rd, input bit exp_wr, input bit exp_err,
                           input string tag, input int reset_at);
    bit   bits [$];
    logic oe_s [128];
    logic out_s [128];
    int   w0, e0, o0, ta2;
    logic [15:0] got;
    logic        all_oe;
    bit          is_rd;

    is_rd = (f.op == 2'b10);
    for (int i = 0; i < f.pre; i++) bits.push_back(1'b1);
    for (int i = 1; i >= 0; i--) bits.push_back(f.st[i]);
    for (int i = 1; i >= 0; i--) bits.push_back(f.op[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(f.phy[i]);
    for (int i = 4; i >= 0; i--) bits.push_back(f.rega[i]);
    for (int i = 1; i >= 0; i--) bits.push_back(is_rd ? 1'b1 : f.ta[i]);
    for (int i = 15; i >= 0; i--) bits.push_back(is_rd ? 1'b1 : f.wdata[i]);

    w0 = wr_cycles; e0 = err_cycles; o0 = oe_cycles;
    for (int i = 0; i < bits.size(); i++) begin
      @(negedge clk); mdc = 1'b0; mdio_st = bits[i];
      repeat (4) @(negedge clk);
      oe_s[i] = mdio_oe; out_s[i] = mdio_out;
      @(negedge clk); mdc = 1'b1;
      repeat (5) @(negedge clk);
      if (i == reset_at) begin
        check({tag, " oe_before_reset"}, 32'(mdio_oe), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check({tag, " oe_after_reset"}, 32'(mdio_oe), 32'd0);
        check({tag, " out_after_reset"}, 32'(mdio_out), 32'd0);
        resetn = 1'b1;
        $display("frame %s: aborted by reset at bit %0d", tag, i);
        return;
      end
    end
    @(negedge clk); mdc = 1'b0; mdio_st = 1'b1;
    repeat (2) @(negedge clk);

    ta2 = f.pre + 15;
    if (exp_rd) begin
      got = '0; all_oe = 1'b1;
      for (int j = 0; j < 16; j++) begin
        got = {got[14:0], out_s[ta2 + 1 + j]};
        all_oe = all_oe & oe_s[ta2 + 1 + j];
      end
      check({tag, " ta1_oe"}, 32'(oe_s[ta2 - 1]), 32'd0);
      check({tag, " ta2_oe"}, 32'(oe_s[ta2]), 32'd1);
      check({tag, " ta2_out"}, 32'(out_s[ta2]), 32'd0);
      check({tag, " rd_data"}, 32'(got), 32'(regfile[f.rega]));
      check({tag, " rd_oe"}, 32'(all_oe), 32'd1);
      check({tag, " rd_adr"}, 32'(reg_rd_adr), 32'(f.rega));
    end else begin
      check({tag, " no_drive"}, 32'(oe_cycles - o0), 32'd0);
    end
    check({tag, " wr_pulses"}, 32'(wr_cycles - w0), 32'(exp_wr));
    if (exp_wr) begin
      check({tag, " wr_adr"}, 32'(seen_wr_adr), 32'(f.rega));
      check({tag, " wr_data"}, 32'(seen_wr_data), 32'(f.wdata));
    end
    check({tag, " err_pulses"}, 32'(err_cycles - e0), 32'(exp_err));
    check({tag, " oe_released"}, 32'(mdio_oe), 32'd0);
    $display("frame %s: pre=%0d st=%b op=%b phy=%0d reg=%0d ta=%b wd=%h exp rd=%0d wr=%0d err=%0d",
             tag, f.pre, f.st, f.op, f.phy, f.rega, f.ta, f.wdata, exp_rd, exp_wr, exp_err);
  endtask

  vec_t   tbl [11];
  frame_t rf;
  bit     prd, pwr, perr;
  int     r;

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 16'($urandom);
    regfile[5] = 16'hBEEF;
    regfile[9] = 16'h1234;

    tbl[0]  = mk(32, 2'b01, 2'b10, 5'd1, 5'd5, 2'b10, 16'h0000, 1, 0, 0);
    tbl[1]  = mk(32, 2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'h00AA, 0, 1, 0);
    tbl[2]  = mk(32, 2'b01, 2'b10, 5'd2, 5'd5, 2'b10, 16'h0000, 0, 0, 0);
    tbl[3]  = mk(32, 2'b01, 2'b10, 5'd1, 5'd5, 2'b10, 16'h0000, 1, 0, 0);
    tbl[4]  = mk(31, 2'b01, 2'b10, 5'd1, 5'd5, 2'b10, 16'h0000, 0, 0, 0);
    tbl[5]  = mk(32, 2'b01, 2'b10, 5'd1, 5'd9, 2'b10, 16'h0000, 1, 0, 0);
    tbl[6]  = mk(32, 2'b01, 2'b11, 5'd1, 5'd5, 2'b10, 16'h5555, 0, 0, 1);
    tbl[7]  = mk(32, 2'b01, 2'b01, 5'd1, 5'd5, 2'b11, 16'h00AA, 0, 0, 1);
    tbl[8]  = mk(32, 2'b00, 2'b10, 5'd1, 5'd5, 2'b10, 16'h0000, 0, 0, 1);
    tbl[9]  = mk(33, 2'b01, 2'b01, 5'd3, 5'd7, 2'b10, 16'hFFFF, 0, 0, 0);
    tbl[10] = mk(32, 2'b01, 2'b01, 5'd1, 5'd2, 2'b00, 16'h8001, 0, 0, 1);

    repeat (5) @(negedge clk);
    check("rst oe", 32'(mdio_oe), 32'd0);
    check("rst out", 32'(mdio_out), 32'd0);
    check("rst rd_adr", 32'(reg_rd_adr), 32'd0);
    check("rst wr_valid", 32'(reg_wr_valid), 32'd0);
    check("rst wr_adr", 32'(reg_wr_adr), 32'd0);
    check("rst wr_data", 32'(reg_wr_data), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_frame(tbl[i].f, tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].exp_err, $sformatf("vec%0d", i), -1);

    // Reset while D8 is on the wire, then a full read must still be served.
    rf = tbl[0].f;
    run_frame(rf, 1, 0, 0, "abort", rf.pre + 16 + 7);
    rf.rega = 5'd9;
    run_frame(rf, 1, 0, 0, "after_abort", -1);

    for (int i = 0; i < 12; i++) begin
      rf.pre   = int'($urandom_range(32, 36));
      rf.st    = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      r        = int'($urandom_range(0, 9));
      rf.op    = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      rf.phy   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : MY_PHY;
      rf.rega  = 5'($urandom);
      rf.ta    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
      rf.wdata = 16'($urandom);
      predict(rf, prd, pwr, perr);
      run_frame(rf, prd, pwr, perr, $sformatf("rnd%0d", i), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDRESS, default 5'b00001, the Clause 22 PHY address this block answers to.
REQ-002 SHALL have parameter MIN_PREAMBLE, default 32, the number of consecutive 1 bits required before ST.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (125 MHz nominal).
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port mdc, input, 1 bit: management clock from the station; asynchronous to clk.
REQ-006 SHALL have port mdio_in, input, 1 bit: pad input value of MDIO.
REQ-007 SHALL have port mdio_out, output, 1 bit: value this block drives onto MDIO.
REQ-008 SHALL have port mdio_oe, output, 1 bit: MDIO drive enable; the top-level IOBUF tristates the pad when this is 0.
REQ-009 SHALL have port reg_rd_adr, output, 5 bits: register address of the current read frame.
REQ-010 SHALL have port reg_rd_data, input, 16 bits: register contents for reg_rd_adr, valid combinationally.
REQ-011 SHALL have port reg_wr_valid, output, 1 bit: one-clk write strobe.
REQ-012 SHALL have port reg_wr_adr, output, 5 bits: write register address.
REQ-013 SHALL have port reg_wr_data, output, 16 bits: write data.
REQ-014 SHALL have port frame_err, output, 1 bit: one-clk pulse on a malformed addressed frame.

Function
REQ-015 SHALL pass mdc and mdio_in through 2-flop synchronizers, detect mdc rising edges (rise = one clk pulse), and sample synced MDIO on rise only.
REQ-016 SHALL operate correctly when MDC high and low phases are each >= 4 clk cycles.
REQ-017 SHALL use states HUNT, START, OP, PHYAD, REGAD, TA, WR_DATA, RD_DATA, SKIP, with a 6-bit bit counter.
REQ-018 HUNT: SHALL count consecutive sampled 1s, saturating at MIN_PREAMBLE, and clear the count on a 0; a 0 sampled when count = MIN_PREAMBLE SHALL move to START as the first ST bit.
REQ-019 START: the second ST bit SHALL be 1, else frame_err pulses and the state returns to HUNT with count 0.
REQ-020 OP: SHALL capture 2 bits; 10 = read, 01 = write; 00 or 11 pulses frame_err and returns to HUNT.
REQ-021 PHYAD/REGAD: SHALL shift in 5 bits each, MSB first.
REQ-022 PHYAD != PHY_ADDRESS SHALL enter SKIP, which consumes the remaining 18 bits (TA + data) without driving and without strobes, then returns to HUNT; no frame_err is raised.
REQ-023 Read: on the rise that samples REGAD bit 0 (edge k), reg_rd_adr SHALL take the captured REGAD in that cycle.
REQ-024 Read: at edge k+1, the block SHALL latch reg_rd_data into the shift register and set mdio_oe=1, mdio_out=0 (second TA bit).
REQ-025 Read: at edges k+2..k+17 the block SHALL drive D15..D0; at edge k+18 mdio_oe SHALL drop to 0 and the state returns to HUNT.
REQ-026 Read: mdio_out/mdio_oe SHALL update one clk after the rise pulse, so the station samples each bit on the following MDC rising edge.
REQ-027 Write: the TA bits SHALL sample as 1,0, else frame_err pulses and the state returns to HUNT.
REQ-028 Write: 16 data bits SHALL be shifted in MSB first; on the rise sampling D0, reg_wr_valid SHALL pulse for exactly one clk with reg_wr_adr/reg_wr_data stable that cycle; then return to HUNT.
REQ-029 Preamble counting SHALL restart after every frame (no preamble suppression).
REQ-030 mdio_oe SHALL be 0 in every state except the TA-bit-2 and RD_DATA drive window.
REQ-031 Input samples SHALL be ignored while mdio_oe=1.

Reset
REQ-032 While resetn=0 at a clk edge: state=HUNT, counters 0, mdio_oe=0, mdio_out=0, reg_rd_adr=0, reg_wr_valid=0, reg_wr_adr=0, reg_wr_data=0, frame_err=0, synchronizers cleared.
REQ-033 Reset asserted mid-frame SHALL release MDIO at the next clk edge; the next frame SHALL require a full MIN_PREAMBLE preamble.

Structure
REQ-034 Package mdio_pkg SHALL hold the state enum, OP_READ=2'b10, OP_WRITE=2'b01, ST=2'b01, field widths and DATA_BITS=16; the same package SHALL be shared with the mdio station block.
REQ-035 Sub-module mdio_sync_edge (2-flop synchronizer plus rise detector for mdc, synchronizer for mdio_in) SHALL be used.

Verification
REQ-036 Read: 32x1, ST 01, OP 10, PHYAD 00001, REGAD 00101, reg_rd_data=16'hBEEF -> reg_rd_adr=5; MDIO shows 0 then BEEF MSB first; oe=0 afterwards.
REQ-037 Write: PHYAD 1, REGAD 5, TA 10, data 16'h00AA -> exactly one reg_wr_valid pulse, adr 5, data 00AA.
REQ-038 PHYAD 00010 read -> mdio_oe stays 0, no strobe, no frame_err; the next correct frame is served.
REQ-039 31-bit preamble then a valid read -> ignored, oe stays 0.
REQ-040 OP 11 -> one frame_err pulse, oe stays 0; write with TA 11 -> one frame_err pulse, no reg_wr_valid.
REQ-041 resetn low during read bit D8 -> mdio_oe=0 on the next clk edge; a following full read of 16'h1234 is correct.
